line_encoder_ser: RTL and testbench
===================================

# line_encoder_ser

Parametrised serialising line encoder. It accepts a WIDTH-bit word over a valid/ready handshake, shifts it out LSB-first one bit per clock, and emits each bit as a 2-bit ternary symbol. Three line codes are selected per word: NRZ, AMI and inverse AMI. Mark polarity is preserved across words. It sits between the data source and the line driver, and replaces the fixed single-bit coder used in Lab 1.

## Interface
Parameters:
- WIDTH, 23, bits per word (≥2)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- data_i  in  WIDTH  word to transmit; bit 0 goes first
- mode_i  in  2  line code, sampled at accept: 0 NRZ, 1 AMI, 2 inverse AMI, 3 reserved (treated as 0)
- valid_i  in  1  data_i/mode_i valid
- ready_o  out  1  block can accept a word this cycle
- code_o  out  2  symbol: 2'b00 zero, 2'b01 +1, 2'b11 −1 (2'b10 never driven)
- code_valid_o  out  1  code_o carries a data symbol
- last_o  out  1  code_o carries bit WIDTH−1 of the current word

## Operation
- Registers: shift register sh[WIDTH−1:0], counter cnt [$clog2(WIDTH)−1:0], mode register md, polarity flag pol (0 = next mark is +1), state {IDLE, SHIFT}.
- Accept occurs when valid_i && ready_o at a rising edge. On that edge:
  - data_i is loaded into sh.
  - mode_i is loaded into md.
  - cnt is set to 0.
  - The symbol for data_i[0] is registered onto code_o.
  - code_valid_o is set to 1 and state moves to SHIFT.
- In SHIFT, each edge without an accept:
  - cnt increments.
  - The symbol for bit cnt+1 is registered.
  - After bit WIDTH−1 has been shown for one cycle, the next edge sets state to IDLE, code_o to 00, and code_valid_o and last_o to 0.
- ready_o = (state==IDLE) || (cnt==WIDTH−1). This is combinational and allows back-to-back words with no gap symbol.
- Symbol rules for a bit b:
  - NRZ: b=1 → 01, b=0 → 11. pol is unchanged.
  - AMI: b=1 is a mark, b=0 → 00.
  - Inverse AMI: b=0 is a mark, b=1 → 00.
  - Mark: emit 01 if pol=0, else 11, then toggle pol.
- pol is never cleared by word boundaries or mode changes, only by reset.
- last_o = 1 exactly while code_valid_o && cnt==WIDTH−1.
- The decoding contract for the verifier: inverse AMI code 00 → bit 1, otherwise bit 0; AMI is the opposite; NRZ: 01 → 1, 11 → 0.

## Timing
- Reset values: code_o=00, code_valid_o=0, last_o=0, ready_o=1 (IDLE), pol=0, cnt=0, sh=0, md=0.
- Latency: the first symbol appears on code_o right after the accept edge, i.e. in the same cycle the word is taken.
- A word occupies exactly WIDTH consecutive cycles of code_valid_o=1.
- Back-to-back: if valid_i=1 during the last-bit cycle, the next word's bit 0 follows on the next edge. code_valid_o stays high and last_o drops.
- valid_i while ready_o=0: ignored. The source holds the word; there is no overflow state.
- rst_i asserted mid-word: all outputs go to their reset values immediately (asynchronous). The partial word is dropped and pol returns to 0.
- mode_i changes during SHIFT have no effect until the next accept.

## Test plan
- Reset, WIDTH=23: assert rst_i mid-run → code_o=00, code_valid_o=0, ready_o=1 with no clock edge. After release, idle output stays 00.
- Inverse AMI, data_i=23'd8201481 (0x7D2509): first four symbols are 00, 01, 11, 00. Over 23 cycles, decoding (00→1, else 0) reassembles 8201481. Marks strictly alternate +/−, and last_o pulses on cycle 23.
- AMI with the same word: the symbol sequence is the bitwise complement pattern of the above. Each 1 bit gives a mark and marks alternate 01/11.
- Polarity carry-over: send AMI 23'h000001, then AMI 23'h000001 back-to-back. The marks are 01 then 11, with no idle gap and code_valid_o continuous for 46 cycles.
- NRZ, data_i=23'h555555: symbols alternate 01, 11, … starting with 01. pol is unchanged, so a following AMI word's first mark is still 01 if pol was 0.
- Handshake: valid_i held high with a new word during SHIFT → no accept until the last-bit cycle. mode_i=3 behaves identically to NRZ.

Source files
------------

// File: rtl/line_encoder_ser.sv
// ============================================================================
// Module      : line_encoder_ser
// Description : Serialising ternary line encoder (NRZ / AMI / inverse AMI),
//               LSB-first, with mark polarity carried across words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_encoder_ser #(
  parameter int WIDTH = 23
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       mode_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [1:0]       code_o,
  output logic             code_valid_o,
  output logic             last_o
);

  localparam int c_cw = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cw-1:0] c_last_cnt = c_cw'(WIDTH - 1);
  localparam logic [c_cw-1:0] c_penult   = c_cw'(WIDTH - 2);
  localparam logic [c_cw-1:0] c_one      = c_cw'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_sh;
  logic [c_cw-1:0]   r_cnt;
  logic [1:0]        r_md;
  logic              r_pol;
  logic [1:0]        r_code;
  logic              r_code_valid;
  logic              r_last;

  logic              w_accept;
  logic [c_cw-1:0]   w_cnt_nxt;
  logic [2:0]        w_first;
  logic [2:0]        w_next;

  // Returns {next polarity, symbol}; modes other than 1 and 2 code as NRZ.
  function automatic logic [2:0] f_symbol(input logic b, input logic [1:0] m, input logic p);
    logic       mark;
    logic [2:0] res;
    mark = 1'b0;
    res  = {p, 2'b00};
    case (m)
      2'd1:    mark = b;
      2'd2:    mark = ~b;
      default: res  = {p, (b ? 2'b01 : 2'b11)};
    endcase
    if (mark) begin
      res = {~p, (p ? 2'b11 : 2'b01)};
    end
    return res;
  endfunction

  assign ready_o   = (r_state == S_IDLE) || (r_cnt == c_last_cnt);
  assign w_accept  = valid_i && ready_o;
  assign w_cnt_nxt = r_cnt + c_one;
  assign w_first   = f_symbol(data_i[0], mode_i, r_pol);
  assign w_next    = f_symbol(r_sh[w_cnt_nxt], r_md, r_pol);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_sh         <= '0;
      r_cnt        <= '0;
      r_md         <= 2'b00;
      r_pol        <= 1'b0;
      r_code       <= 2'b00;
      r_code_valid <= 1'b0;
      r_last       <= 1'b0;
    end else if (w_accept) begin
      r_state         <= S_SHIFT;
      r_sh            <= data_i;
      r_md            <= mode_i;
      r_cnt           <= '0;
      {r_pol, r_code} <= w_first;
      r_code_valid    <= 1'b1;
      r_last          <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      if (r_cnt == c_last_cnt) begin
        r_state      <= S_IDLE;
        r_code       <= 2'b00;
        r_code_valid <= 1'b0;
        r_last       <= 1'b0;
      end else begin
        r_cnt           <= w_cnt_nxt;
        {r_pol, r_code} <= w_next;
        r_last          <= (r_cnt == c_penult);
      end
    end
  end

  assign code_o       = r_code;
  assign code_valid_o = r_code_valid;
  assign last_o       = r_last;

endmodule

`default_nettype wire

// File: tb/tb_line_encoder_ser.sv
// ============================================================================
// Module      : tb_line_encoder_ser
// Description : Directed self-checking bench for line_encoder_ser (WIDTH=23).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_line_encoder_ser;

  localparam int WIDTH = 23;

  logic              CLK_tb = 1'b0;
  logic              rst;
  logic [WIDTH-1:0]  data;
  logic [1:0]        mode;
  logic              valid;
  logic              ready;
  logic [1:0]        code;
  logic              code_valid;
  logic              last;

  int   checks = 0;
  int   errors = 0;
  logic exp_pol = 1'b0;

  always #5 CLK_tb = ~CLK_tb;

  line_encoder_ser #(.WIDTH(WIDTH)) dut (
    .clk_i        (CLK_tb),
    .rst_i        (rst),
    .data_i       (data),
    .mode_i       (mode),
    .valid_i      (valid),
    .ready_o      (ready),
    .code_o       (code),
    .code_valid_o (code_valid),
    .last_o       (last)
  );

  // Reference symbol from the line-code rules; advances the expected polarity.
  function automatic logic [1:0] model_sym(input logic b, input logic [1:0] m);
    logic       mk;
    logic [1:0] s;
    mk = 1'b0;
    s  = 2'b00;
    if (m == 2'd1)      mk = b;
    else if (m == 2'd2) mk = ~b;
    else                s  = b ? 2'b01 : 2'b11;
    if (mk) begin
      s       = exp_pol ? 2'b11 : 2'b01;
      exp_pol = ~exp_pol;
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge CLK_tb);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; data = '0; mode = 2'd0;
    #12;
    checks++;
    if (code !== 2'b00 || code_valid !== 1'b0 || last !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: code=%b cv=%b last=%b ready=%b, required 00 0 0 1", code, code_valid, last, ready);
    end
    @(negedge CLK_tb);
    rst = 1'b0;
    exp_pol = 1'b0;
    tick();
    checks++;
    if (code !== 2'b00 || code_valid !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: code=%b cv=%b ready=%b, required 00 0 1", code, code_valid, ready);
    end
  endtask

  task automatic test_inv_ami();
    logic [WIDTH-1:0] d, dec;
    logic [1:0]       hand [4];
    logic [1:0]       e;
    d = 23'h7D2509;
    hand = '{2'b00, 2'b01, 2'b11, 2'b00};
    dec = '0;
    @(negedge CLK_tb);
    data = d; mode = 2'd2; valid = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      tick();
      if (i == 0) valid = 1'b0;
      e = model_sym(d[i], 2'd2);
      checks++;
      if (code !== e || code_valid !== 1'b1 || last !== (i == WIDTH-1) || ready !== (i == WIDTH-1)) begin
        errors++;
        $display("FAIL inv_ami bit %0d: code=%b cv=%b last=%b ready=%b, required code=%b", i, code, code_valid, last, ready, e);
      end
      if (i < 4) begin
        checks++;
        if (code !== hand[i]) begin
          errors++;
          $display("FAIL inv_ami_first sym %0d: code=%b, required %b", i, code, hand[i]);
        end
      end
      dec[i] = (code == 2'b00);
    end
    checks++;
    if (dec !== d) begin
      errors++;
      $display("FAIL inv_ami_decode: got %h, required %h", dec, d);
    end
    tick();
    checks++;
    if (code !== 2'b00 || code_valid !== 1'b0 || last !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL inv_ami_idle: code=%b cv=%b last=%b ready=%b, required 00 0 0 1", code, code_valid, last, ready);
    end
  endtask

  task automatic test_ami();
    logic [WIDTH-1:0] d, dec;
    logic [1:0]       hand [4];
    logic [1:0]       e;
    d = 23'h7D2509;
    hand = '{2'b01, 2'b00, 2'b00, 2'b11};
    dec = '0;
    @(negedge CLK_tb);
    data = d; mode = 2'd1; valid = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      tick();
      if (i == 0) valid = 1'b0;
      e = model_sym(d[i], 2'd1);
      checks++;
      if (code !== e || code_valid !== 1'b1 || last !== (i == WIDTH-1)) begin
        errors++;
        $display("FAIL ami bit %0d: code=%b cv=%b last=%b, required code=%b", i, code, code_valid, last, e);
      end
      if (i < 4) begin
        checks++;
        if (code !== hand[i]) begin
          errors++;
          $display("FAIL ami_first sym %0d: code=%b, required %b", i, code, hand[i]);
        end
      end
      dec[i] = (code != 2'b00);
    end
    checks++;
    if (dec !== d) begin
      errors++;
      $display("FAIL ami_decode: got %h, required %h", dec, d);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    @(negedge CLK_tb);
    data = 23'h7FFFFF; mode = 2'd1; valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (5) tick();
    #3;
    rst = 1'b1;
    #1;
    exp_pol = 1'b0;
    checks++;
    if (code !== 2'b00 || code_valid !== 1'b0 || last !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: code=%b cv=%b last=%b ready=%b, required 00 0 0 1", code, code_valid, last, ready);
    end
    @(negedge CLK_tb);
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (code !== 2'b00 || code_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: code=%b cv=%b, required 00 0", code, code_valid);
    end
  endtask

  task automatic test_polarity();
    logic [WIDTH-1:0] d;
    logic [1:0]       e;
    int               k;
    d = 23'h000001;
    @(negedge CLK_tb);
    data = d; mode = 2'd1; valid = 1'b1;
    for (int i = 0; i < 2*WIDTH; i++) begin
      tick();
      if (i == WIDTH) valid = 1'b0;
      k = i % WIDTH;
      e = model_sym(d[k], 2'd1);
      checks++;
      if (code !== e || code_valid !== 1'b1 || last !== (k == WIDTH-1) || ready !== (k == WIDTH-1)) begin
        errors++;
        $display("FAIL polarity cycle %0d: code=%b cv=%b last=%b ready=%b, required code=%b", i, code, code_valid, last, ready, e);
      end
      if (i == 0 || i == WIDTH) begin
        checks++;
        if (code !== ((i == 0) ? 2'b01 : 2'b11)) begin
          errors++;
          $display("FAIL polarity_mark cycle %0d: code=%b, required %b", i, code, (i == 0) ? 2'b01 : 2'b11);
        end
      end
    end
    tick();
    checks++;
    if (code_valid !== 1'b0 || code !== 2'b00) begin
      errors++;
      $display("FAIL polarity_idle: code=%b cv=%b, required 00 0", code, code_valid);
    end
  endtask

  task automatic test_nrz();
    logic [WIDTH-1:0] d0, d1;
    logic [1:0]       e;
    int               k;
    d0 = 23'h555555;
    d1 = 23'h000001;
    @(negedge CLK_tb);
    data = d0; mode = 2'd0; valid = 1'b1;
    for (int i = 0; i < 2*WIDTH; i++) begin
      tick();
      if (i == 0) begin data = d1; mode = 2'd1; end
      if (i == WIDTH) valid = 1'b0;
      k = i % WIDTH;
      e = (i < WIDTH) ? model_sym(d0[k], 2'd0) : model_sym(d1[k], 2'd1);
      checks++;
      if (code !== e || code_valid !== 1'b1 || last !== (k == WIDTH-1)) begin
        errors++;
        $display("FAIL nrz cycle %0d: code=%b cv=%b last=%b, required code=%b", i, code, code_valid, last, e);
      end
      if (i < WIDTH) begin
        checks++;
        if (code !== ((i % 2 == 0) ? 2'b01 : 2'b11)) begin
          errors++;
          $display("FAIL nrz_alt bit %0d: code=%b, required %b", i, code, (i % 2 == 0) ? 2'b01 : 2'b11);
        end
      end
      if (i == WIDTH) begin
        checks++;
        if (code !== 2'b01) begin
          errors++;
          $display("FAIL nrz_pol_kept: code=%b, required 01", code);
        end
      end
    end
    tick();
  endtask

  task automatic test_handshake();
    logic [WIDTH-1:0] a, b;
    logic [1:0]       e;
    int               k;
    a = 23'h2A5F3C;
    b = 23'h13579B;
    @(negedge CLK_tb);
    data = a; mode = 2'd3; valid = 1'b1;
    for (int i = 0; i < 2*WIDTH; i++) begin
      tick();
      if (i == 0)  begin data = b; mode = 2'd1; end
      if (i == 10) mode = 2'd2;
      if (i == WIDTH) valid = 1'b0;
      k = i % WIDTH;
      e = (i < WIDTH) ? model_sym(a[k], 2'd0) : model_sym(b[k], 2'd2);
      checks++;
      if (code !== e || code_valid !== 1'b1 || last !== (k == WIDTH-1) || ready !== (k == WIDTH-1)) begin
        errors++;
        $display("FAIL handshake cycle %0d: code=%b cv=%b last=%b ready=%b, required code=%b", i, code, code_valid, last, ready, e);
      end
      if (i == 0) begin
        checks++;
        if (code !== 2'b11) begin
          errors++;
          $display("FAIL mode3_as_nrz: code=%b, required 11", code);
        end
      end
    end
    tick();
    checks++;
    if (code !== 2'b00 || code_valid !== 1'b0 || last !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL handshake_idle: code=%b cv=%b last=%b ready=%b, required 00 0 0 1", code, code_valid, last, ready);
    end
  endtask

  initial begin
    test_reset();
    test_inv_ami();
    test_ami();
    test_reset_mid();
    test_polarity();
    test_nrz();
    test_handshake();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
